// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and frame constants.
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_bps_counter.sv
// Baud-period counter for the transmitter: strobes bit_end on the last cycle
// of each bit period and sits at zero whenever counting is disabled.
module uart_tx_bps_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic count_enable,
   output logic bit_end
);

   localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (count_enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign bit_end = count_enable && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_control.sv
// UART transmit control: start bit, 8 data bits MSB first, STOP_BITS stop bits,
// with a registered tx line, busy flag and one-cycle completion pulse.
module uart_tx_control
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_enable_signal,
   input  logic [7:0] tx_data,
   input  logic       tx_start_signal,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_out,
   output logic       tx_done_signal
);

   localparam logic [2:0] MSB_IDX   = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic       tx_out_q, tx_out_d;
   logic       tx_busy_q, tx_busy_d;
   logic       tx_done_q, tx_done_d;
   logic       bit_end;
   logic       accept;
   logic       count_enable;

   assign tx_ready     = (state_q == TX_IDLE) && tx_enable_signal && !rst;
   assign accept       = tx_start_signal && tx_ready;
   assign count_enable = (state_q != TX_IDLE) && tx_enable_signal;

   uart_tx_bps_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bps (
      .clk         (clk),
      .rst         (rst),
      .count_enable(count_enable),
      .bit_end     (bit_end)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      tx_done_d  = 1'b0;

      case (state_q)
         TX_IDLE: begin
            bit_idx_d  = MSB_IDX;
            stop_cnt_d = 1'b0;
            if (accept) begin
               state_d = TX_START;
               shift_d = tx_data;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_d   = TX_DATA;
               bit_idx_d = MSB_IDX;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd0) begin
                  state_d    = TX_STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_idx_d = bit_idx_q - 3'd1;
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d   = TX_IDLE;
                  tx_done_d = 1'b1;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase

      // Dropping enable mid-frame abandons the byte silently.
      if ((state_q != TX_IDLE) && !tx_enable_signal) begin
         state_d   = TX_IDLE;
         bit_idx_d = MSB_IDX;
         tx_done_d = 1'b0;
      end

      tx_busy_d = (state_d != TX_IDLE);

      // Line level is decoded from the next state so it lands with the state change.
      case (state_d)
         TX_START: tx_out_d = 1'b0;
         TX_DATA:  tx_out_d = shift_d[bit_idx_d];
         default:  tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= MSB_IDX;
         stop_cnt_q <= 1'b0;
         tx_out_q   <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         tx_out_q   <= tx_out_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign tx_out         = tx_out_q;
   assign tx_busy        = tx_busy_q;
   assign tx_done_signal = tx_done_q;

endmodule

// File: tb/tb_uart_tx_control.sv
// Bench for uart_tx_control: per-cycle waveform checks from a frame table plus
// a loopback receiver that pops expected bytes from a scoreboard queue.
module tb_uart_tx_control;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] data;
   logic       start;
   logic       ready1, busy1, out1, done1;
   logic       ready2, busy2, out2, done2;
   logic       use2;
   logic       ready_m, busy_m, out_m, done_m;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done1  = 0;
   int n_done2  = 0;
   logic [7:0] exp_q[$];

   uart_tx_control #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .tx_enable_signal(en), .tx_data(data),
      .tx_start_signal(start), .tx_ready(ready1), .tx_busy(busy1),
      .tx_out(out1), .tx_done_signal(done1)
   );

   uart_tx_control #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .tx_enable_signal(en), .tx_data(data),
      .tx_start_signal(start), .tx_ready(ready2), .tx_busy(busy2),
      .tx_out(out2), .tx_done_signal(done2)
   );

   assign ready_m = use2 ? ready2 : ready1;
   assign busy_m  = use2 ? busy2  : busy1;
   assign out_m   = use2 ? out2   : out1;
   assign done_m  = use2 ? done2  : done1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loopback receiver on the STOP_BITS=1 instance, sampling mid-bit.
   logic       rx_act = 1'b0;
   int         rx_c   = 0;
   logic [7:0] rx_sh  = '0;
   always @(negedge clk) begin
      if (done1) n_done1++;
      if (done2) n_done2++;
      if (rst || !en) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (out1 == 1'b0) begin
            rx_act = 1'b1;
            rx_c   = 0;
         end
      end else begin
         rx_c++;
         if (rx_c == 2) chk("rx_start_bit", out1, 1'b0);
         if ((rx_c > 2) && (rx_c < 38) && ((rx_c % CPB) == 2)) rx_sh = {rx_sh[6:0], out1};
         if (rx_c == 38) begin
            chk("rx_stop_bit", out1, 1'b1);
            if (exp_q.size() == 0) begin
               chk("rx_unexpected_frame", 32'd1, 32'd0);
            end else begin
               chk("rx_byte", rx_sh, exp_q.pop_front());
               $display("rx frame 0x%02h at %0t", rx_sh, $time);
            end
            rx_act = 1'b0;
         end
      end
   end

   // Starts in cycle T+1; leaves the bench in the done cycle.
   task automatic check_frame(input logic [10:0] pat, input int stop, input int glitch);
      int len;
      len = (9 + stop) * CPB;
      for (int k = 0; k < len; k++) begin
         if (glitch >= 0) start = (k == glitch);
         chk("frame_out", out_m, pat[10 - k / CPB]);
         chk("frame_busy", busy_m, 1'b1);
         chk("frame_done_early", done_m, 1'b0);
         tick();
      end
      if (glitch >= 0) start = 1'b0;
      chk("done_pulse", done_m, 1'b1);
      chk("done_busy", busy_m, 1'b0);
      chk("done_out", out_m, 1'b1);
      chk("done_ready", ready_m, 1'b1);
   endtask

   task automatic send(input logic [7:0] d, input logic [10:0] pat, input int stop, input int glitch);
      data  = d;
      start = 1'b1;
      #1;
      chk("ready_before_accept", ready_m, 1'b1);
      exp_q.push_back(d);
      tick();
      start = 1'b0;
      data  = ~d;
      check_frame(pat, stop, glitch);
      tick();
      chk("done_single", done_m, 1'b0);
      $display("sent 0x%02h stop_bits=%0d at %0t", d, stop, $time);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic idle_checks(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk("idle_out", out_m, 1'b1);
         chk("idle_busy", busy_m, 1'b0);
         chk("idle_done", done_m, 1'b0);
      end
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [10:0] pat;
   } vec_t;
   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 11'b01010010111};
      vecs[1] = '{8'h00, 11'b00000000011};
      vecs[2] = '{8'hFF, 11'b01111111111};
      vecs[3] = '{8'h81, 11'b01000000111};
      vecs[4] = '{8'h3C, 11'b00011110011};
      vecs[5] = '{8'h5A, 11'b00101101011};

      use2 = 1'b0; rst = 1'b1; en = 1'b1; start = 1'b0; data = 8'h00;
      repeat (3) tick();
      chk("rst_out", out1, 1'b1);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_done", done1, 1'b0);
      chk("rst_ready", ready1, 1'b0);
      chk("rst_out2", out2, 1'b1);
      chk("rst_ready2", ready2, 1'b0);
      rst = 1'b0;
      #1;
      chk("idle_ready", ready1, 1'b1);
      en = 1'b0;
      #1;
      chk("disabled_ready", ready1, 1'b0);
      en = 1'b1;
      idle_checks(4);

      for (int i = 0; i < 6; i++) begin
         send(vecs[i].data, vecs[i].pat, 1, -1);
      end

      // Back-to-back 0x00 then 0xFF with start held high.
      do_reset();
      n_done1 = 0;
      data  = 8'h00;
      start = 1'b1;
      exp_q.push_back(8'h00);
      tick();
      data = 8'hFF;
      check_frame(vecs[1].pat, 1, -1);
      exp_q.push_back(8'hFF);
      tick();
      start = 1'b0;
      data  = 8'h00;
      chk("b2b_second_start", out1, 1'b0);
      check_frame(vecs[2].pat, 1, -1);
      tick();
      chk("b2b_done_count", n_done1, 2);

      // Start request while busy is ignored.
      do_reset();
      n_done1 = 0;
      send(8'hA5, vecs[0].pat, 1, 10);
      idle_checks(6);
      chk("glitch_done_count", n_done1, 1);

      // Same on the two-stop-bit instance.
      do_reset();
      use2 = 1'b1;
      n_done2 = 0;
      send(8'h5A, vecs[5].pat, 2, 10);
      idle_checks(6);
      chk("stop2_done_count", n_done2, 1);
      use2 = 1'b0;

      // Abort during data bit 3 of 0x3C.
      do_reset();
      n_done1 = 0;
      data  = 8'h3C;
      start = 1'b1;
      exp_q.push_back(8'h3C);
      tick();
      start = 1'b0;
      data  = 8'h00;
      for (int k = 0; k < 21; k++) begin
         chk("abort_pre_out", out1, vecs[4].pat[10 - k / CPB]);
         tick();
      end
      en = 1'b0;
      tick();
      chk("abort_out", out1, 1'b1);
      chk("abort_busy", busy1, 1'b0);
      chk("abort_ready_disabled", ready1, 1'b0);
      en = 1'b1;
      #1;
      chk("abort_ready", ready1, 1'b1);
      void'(exp_q.pop_back());
      idle_checks(8);
      chk("abort_done_count", n_done1, 0);
      send(8'h81, vecs[3].pat, 1, -1);

      // Reset during the start bit.
      do_reset();
      n_done1 = 0;
      data  = 8'h5A;
      start = 1'b1;
      exp_q.push_back(8'h5A);
      tick();
      start = 1'b0;
      data  = 8'hA5;
      tick();
      chk("midrst_start_out", out1, 1'b0);
      rst = 1'b1;
      tick();
      chk("midrst_out", out1, 1'b1);
      chk("midrst_busy", busy1, 1'b0);
      chk("midrst_ready", ready1, 1'b0);
      rst = 1'b0;
      void'(exp_q.pop_back());
      idle_checks(6);
      chk("midrst_done_count", n_done1, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
